// File: rtl/decoder_arbiter.sv
// rtl/decoder_arbiter.sv - round-robin time-multiplexer of one spike decoder across N_SRC spike sources
module decoder_arbiter #(
    parameter int N_SRC        = 4,
    parameter int SLOT_CYCLES  = 80,
    parameter int FLUSH_CYCLES = 2,
    localparam int SRC_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   src_req,
    input  logic [4*N_SRC-1:0] src_spike,
    output logic               dec_rst_n,
    output logic [3:0]         dec_spike,
    input  logic [7:0]         dec_char,
    input  logic               dec_valid,
    output logic [N_SRC-1:0]   grant,
    output logic               busy,
    output logic               result_valid,
    output logic [SRC_W-1:0]   result_src,
    output logic [7:0]         result_char,
    output logic               result_timeout
);

    localparam int SLOT_W  = $clog2(SLOT_CYCLES);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_REPORT
    } state_t;

    state_t state, state_nx;

    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   rr_last;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [N_SRC-1:0]   pick_onehot;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [3:0]         spike_sel;
    logic               gnt_req;
    logic               slot_last;

    logic load_grant;
    logic end_slot;
    logic capture;
    logic cap_timeout;

    // Scan starts just past the last served source so a held request cannot starve others.
    always_comb begin
        int cand;
        cand        = 0;
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = (int'(rr_last) + k) % N_SRC;
            if (!pick_valid && src_req[cand]) begin
                pick_valid        = 1'b1;
                pick_idx          = SRC_W'(cand);
                pick_onehot[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        spike_sel = 4'b0000;
        gnt_req   = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                spike_sel = src_spike[4*i +: 4];
                gnt_req   = src_req[i];
            end
        end
    end

    assign slot_last = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        load_grant  = 1'b0;
        end_slot    = 1'b0;
        capture     = 1'b0;
        cap_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    load_grant = 1'b1;
                    state_nx   = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!gnt_req) begin
                    end_slot = 1'b1;
                    state_nx = S_IDLE;
                end else if (flush_cnt == FLUSH_W'(1)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (!gnt_req) begin
                    end_slot = 1'b1;
                    state_nx = S_IDLE;
                end else if (dec_valid) begin
                    capture  = 1'b1;
                    state_nx = S_REPORT;
                end else if (slot_last) begin
                    capture     = 1'b1;
                    cap_timeout = 1'b1;
                    state_nx    = S_REPORT;
                end
            end
            S_REPORT: begin
                end_slot = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Decoder is released only while RUN, so each slot starts from a clean decoder.
    assign dec_rst_n    = (state == S_RUN);
    assign dec_spike    = (state == S_RUN) ? spike_sel : 4'b0000;
    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_REPORT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant          <= '0;
            gnt_idx        <= '0;
            rr_last        <= SRC_W'(N_SRC - 1);
            flush_cnt      <= '0;
            slot_cnt       <= '0;
            result_src     <= '0;
            result_char    <= 8'h20;
            result_timeout <= 1'b0;
        end else begin
            if (load_grant) begin
                grant     <= pick_onehot;
                gnt_idx   <= pick_idx;
                flush_cnt <= FLUSH_W'(FLUSH_CYCLES);
            end
            if (end_slot) begin
                grant   <= '0;
                rr_last <= gnt_idx;
            end
            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt - FLUSH_W'(1);
                slot_cnt  <= '0;
            end
            if (state == S_RUN && !slot_last) begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (capture) begin
                result_src     <= gnt_idx;
                result_char    <= cap_timeout ? 8'h20 : dec_char;
                result_timeout <= cap_timeout;
            end
        end
    end

endmodule

// File: tb/tb_decoder_arbiter.sv
// tb/tb_decoder_arbiter.sv - directed self-checking bench for decoder_arbiter with a behavioural decoder
module tb_decoder_arbiter;

    localparam int N_SRC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_req;
    logic [15:0] src_spike;
    logic        dec_rst_n;
    logic [3:0]  dec_spike;
    logic [7:0]  dec_char;
    logic        dec_valid;
    logic [3:0]  grant;
    logic        busy;
    logic        result_valid;
    logic [1:0]  result_src;
    logic [7:0]  result_char;
    logic        result_timeout;

    int checks = 0;
    int passed = 0;
    int dec_cnt = 0;

    decoder_arbiter #(.N_SRC(4), .SLOT_CYCLES(80), .FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .src_req(src_req),
        .src_spike(src_spike),
        .dec_rst_n(dec_rst_n),
        .dec_spike(dec_spike),
        .dec_char(dec_char),
        .dec_valid(dec_valid),
        .grant(grant),
        .busy(busy),
        .result_valid(result_valid),
        .result_src(result_src),
        .result_char(result_char),
        .result_timeout(result_timeout)
    );

    always #5 clk = ~clk;

    // Decoder stand-in: confirms a known pattern on its 4th released cycle; zero pattern never confirms.
    always @(posedge clk) begin
        dec_cnt <= dec_rst_n ? dec_cnt + 1 : 0;
    end

    always_comb begin
        dec_char = 8'h00;
        case (dec_spike)
            4'b0001: dec_char = 8'h41;
            4'b0011: dec_char = 8'h45;
            4'b1100: dec_char = 8'h46;
            4'b1000: dec_char = 8'h44;
            default: dec_char = 8'h00;
        endcase
        dec_valid = dec_rst_n && (dec_char != 8'h00) && (dec_cnt == 3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input int limit, output int run_cycles, output bit seen);
        run_cycles = 0;
        seen       = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (dec_rst_n) run_cycles++;
            if (result_valid) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        bit seen;
        logic [3:0] exp_g [5];
        logic [7:0] exp_c [5];
        logic [1:0] exp_s [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_c = '{8'h41, 8'h45, 8'h46, 8'h44, 8'h41};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst       = 1'b1;
        src_req   = 4'b0000;
        src_spike = 16'h0000;
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_dec_rst_n", dec_rst_n, 1'b0);
        check("rst_dec_spike", dec_spike, 4'b0000);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_result_src", result_src, 2'd0);
        check("rst_result_char", result_char, 8'h20);
        check("rst_result_timeout", result_timeout, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Single source 1 with pattern 0011 -> 'E'
        src_spike = 16'h0030;
        src_req   = 4'b0010;
        tick();
        check("single_grant", grant, 4'b0010);
        check("single_busy", busy, 1'b1);
        check("single_flush1", dec_rst_n, 1'b0);
        tick();
        check("single_flush2", dec_rst_n, 1'b0);
        tick();
        check("single_run_rst_n", dec_rst_n, 1'b1);
        check("single_run_spike", dec_spike, 4'b0011);
        wait_result(100, run, seen);
        check("single_seen", seen, 1'b1);
        check("single_run_cycles", run + 1, 4);
        check("single_src", result_src, 2'd1);
        check("single_char", result_char, 8'h45);
        check("single_timeout", result_timeout, 1'b0);
        check("single_report_rst_n", dec_rst_n, 1'b0);
        src_req = 4'b0000;
        tick();
        check("single_idle_grant", grant, 4'b0000);
        check("single_pulse_one_cycle", result_valid, 1'b0);
        check("single_hold_char", result_char, 8'h45);

        // Timeout: source 0 with silent pattern
        src_spike = 16'h0000;
        src_req   = 4'b0001;
        wait_result(200, run, seen);
        check("timeout_seen", seen, 1'b1);
        check("timeout_run_cycles", run, 80);
        check("timeout_src", result_src, 2'd0);
        check("timeout_char", result_char, 8'h20);
        check("timeout_flag", result_timeout, 1'b1);
        src_req = 4'b0000;
        tick();

        // Round-robin with all four requesting, fresh from reset
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        src_spike = 16'h8C31;
        src_req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), grant, exp_g[k]);
            wait_result(100, run, seen);
            check($sformatf("rr_seen%0d", k), seen, 1'b1);
            check($sformatf("rr_src%0d", k), result_src, exp_s[k]);
            check($sformatf("rr_char%0d", k), result_char, exp_c[k]);
            check($sformatf("rr_timeout%0d", k), result_timeout, 1'b0);
            if (k == 4) src_req = 4'b0000;
            tick();
            check($sformatf("rr_gap%0d", k), grant, 4'b0000);
        end

        // Abort source 1 mid-RUN; re-request must still go to source 2
        src_spike = 16'h8C01;
        src_req   = 4'b0110;
        tick();
        check("abort_grant", grant, 4'b0010);
        tick();
        tick();
        check("abort_in_run", dec_rst_n, 1'b1);
        tick();
        src_req = 4'b0100;
        tick();
        check("abort_idle_grant", grant, 4'b0000);
        check("abort_idle_busy", busy, 1'b0);
        check("abort_no_result", result_valid, 1'b0);
        check("abort_rst_n", dec_rst_n, 1'b0);
        src_req = 4'b0110;
        tick();
        check("abort_next_grant", grant, 4'b0100);
        src_req = 4'b0000;
        tick();
        check("abort_flush_grant", grant, 4'b0000);
        check("abort_hold_src", result_src, 2'd0);

        // Async reset while the decoder is about to confirm
        src_req = 4'b1000;
        tick();
        check("areset_grant", grant, 4'b1000);
        for (int i = 0; i < 5; i++) tick();
        check("areset_run", dec_rst_n, 1'b1);
        rst = 1'b1;
        #1;
        check("areset_grant_now", grant, 4'b0000);
        check("areset_rst_n_now", dec_rst_n, 1'b0);
        check("areset_no_result", result_valid, 1'b0);
        tick();
        check("areset_held_no_result", result_valid, 1'b0);
        check("areset_result_char", result_char, 8'h20);
        rst     = 1'b0;
        src_req = 4'b1001;
        tick();
        check("areset_src0_wins", grant, 4'b0001);
        src_req = 4'b0000;
        tick();
        check("areset_final_idle", grant, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
